// File: rtl/video_pkg.sv
// Shared types and default 800x480 timing for the video output stage.
// Optional test pattern build: define VIDEO_TEST_PATTERN_EN.
package video_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        WAIT_FULL,
        WAIT_SOF,
        RUN
    } state_t;

    localparam int H_DISP   = 800;
    localparam int H_FP     = 40;
    localparam int H_PULSE  = 48;
    localparam int H_BP     = 40;
    localparam int V_DISP   = 480;
    localparam int V_FP     = 13;
    localparam int V_PULSE  = 3;
    localparam int V_BP     = 29;

endpackage

// File: rtl/video_timing_gen_if.sv
// FIFO-side and transmitter-side signals of the video output stage.
// master = timing generator, slave = FIFO / transmitter environment.
interface video_timing_gen_if;

    logic [23:0] fifo_rdata;
    logic        fifo_empty;
    logic        fifo_full;
    logic        fifo_read;
    logic        video_hs;
    logic        video_vs;
    logic        video_blank;
    logic [23:0] video_rgb;
    logic        underflow;

    modport master (
        input  fifo_rdata,
        input  fifo_empty,
        input  fifo_full,
        output fifo_read,
        output video_hs,
        output video_vs,
        output video_blank,
        output video_rgb,
        output underflow
    );

    modport slave (
        output fifo_rdata,
        output fifo_empty,
        output fifo_full,
        input  fifo_read,
        input  video_hs,
        input  video_vs,
        input  video_blank,
        input  video_rgb,
        input  underflow
    );

endinterface

// File: rtl/video_timing_gen_sync_counter.sv
// One timing axis: counter wrapping at FP+PULSE+BP+DISP with decoded regions.
// Region order is front porch, sync, back porch, active.
module sync_counter #(
    parameter  int FP    = 40,
    parameter  int PULSE = 48,
    parameter  int BP    = 40,
    parameter  int DISP  = 800,
    localparam int TOTAL = FP + PULSE + BP + DISP,
    localparam int W     = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic         wrap,
    output logic         sync_n,
    output logic         active,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] SYNC_LO = W'(FP);
    localparam logic [W-1:0] SYNC_HI = W'(FP + PULSE);
    localparam logic [W-1:0] ACT_LO  = W'(TOTAL - DISP);

    assign wrap   = en && (count == LAST);
    assign sync_n = !((count >= SYNC_LO) && (count < SYNC_HI));
    assign active = (count >= ACT_LO);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Pixel-domain output stage: sync/blank timing plus FIFO-fed RGB.
// Define VIDEO_TEST_PATTERN_EN to replace FIFO data with 8 colour bars.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int HDISP  = H_DISP,
    parameter int HFP    = H_FP,
    parameter int HPULSE = H_PULSE,
    parameter int HBP    = H_BP,
    parameter int VDISP  = V_DISP,
    parameter int VFP    = V_FP,
    parameter int VPULSE = V_PULSE,
    parameter int VBP    = V_BP
) (
    input logic                pixel_clk,
    input logic                pixel_rst,
    video_timing_gen_if.master vif
);

    localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
    localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);

    logic          hwrap;
    logic          vwrap;
    logic          hsync_n;
    logic          vsync_n;
    logic          hact;
    logic          vact;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          active;
    logic          pop;
    logic          unused_cnt;
    state_t        state_q;
    state_t        state_d;
    rgb_t          pix_d;

    sync_counter #(
        .FP    (HFP),
        .PULSE (HPULSE),
        .BP    (HBP),
        .DISP  (HDISP)
    ) u_hcnt (
        .clk    (pixel_clk),
        .rst    (pixel_rst),
        .en     (1'b1),
        .wrap   (hwrap),
        .sync_n (hsync_n),
        .active (hact),
        .count  (hcount)
    );

    sync_counter #(
        .FP    (VFP),
        .PULSE (VPULSE),
        .BP    (VBP),
        .DISP  (VDISP)
    ) u_vcnt (
        .clk    (pixel_clk),
        .rst    (pixel_rst),
        .en     (hwrap),
        .wrap   (vwrap),
        .sync_n (vsync_n),
        .active (vact),
        .count  (vcount)
    );

    assign active     = hact & vact;
    assign unused_cnt = ^{hcount, vcount};

    // vwrap is high only on the last pixel of the last line
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
`ifdef VIDEO_TEST_PATTERN_EN
        state_d = RUN;
`else
        unique case (state_q)
            WAIT_FULL: if (vif.fifo_full) state_d = WAIT_SOF;
            WAIT_SOF:  if (vwrap) state_d = RUN;
            RUN:       pop = active;
            default:   state_d = WAIT_FULL;
        endcase
`endif
    end

    assign vif.fifo_read = pop;

`ifdef VIDEO_TEST_PATTERN_EN
    localparam int BAR_W = HDISP / 8;

    logic [HW-1:0] hoff;
    logic [2:0]    bar;
    logic          unused_fifo;

    assign hoff        = hcount - HW'(HTOTAL - HDISP);
    assign bar         = 3'(hoff / HW'(BAR_W));
    assign unused_fifo = ^{vif.fifo_rdata, vif.fifo_empty, vif.fifo_full};

    always_comb begin
        pix_d = '0;
        if (active && (state_q == RUN)) begin
            pix_d.r = {8{~bar[2]}};
            pix_d.g = {8{~bar[1]}};
            pix_d.b = {8{~bar[0]}};
        end
    end
`else
    always_comb begin
        pix_d = '0;
        if (pop && !vif.fifo_empty) pix_d = vif.fifo_rdata;
    end
`endif

    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            state_q         <= WAIT_FULL;
            vif.video_hs    <= 1'b1;
            vif.video_vs    <= 1'b1;
            vif.video_blank <= 1'b0;
            vif.video_rgb   <= '0;
            vif.underflow   <= 1'b0;
        end else begin
            state_q         <= state_d;
            vif.video_hs    <= hsync_n;
            vif.video_vs    <= vsync_n;
            vif.video_blank <= active;
            vif.video_rgb   <= pix_d;
            vif.underflow   <= vif.underflow | (pop & vif.fifo_empty);
        end
    end

endmodule
